// File: rtl/alu_rs.sv
// Reservation station in front of scalar_alu: buffers dispatched ops, snoops the ALU and LSB result
// buses, and issues the lowest-slot ready op each cycle. Option: ALU_RS_WAKEUP_BYPASS_EN.
module alu_rs #(
    parameter int unsigned RS_SIZE       = 8,
    parameter int unsigned ROB_WIDTH_BIT = 4,
    parameter int unsigned RS_TYPE_BIT   = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     disp_valid,
    input  logic [RS_TYPE_BIT-1:0]   disp_type,
    input  logic [31:0]              disp_vj,
    input  logic [31:0]              disp_vk,
    input  logic                     disp_has_qj,
    input  logic                     disp_has_qk,
    input  logic [ROB_WIDTH_BIT-1:0] disp_qj,
    input  logic [ROB_WIDTH_BIT-1:0] disp_qk,
    input  logic [ROB_WIDTH_BIT-1:0] disp_rob_id,
    input  logic                     cdb_alu_ready,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_alu_rob_id,
    input  logic [31:0]              cdb_alu_value,
    input  logic                     cdb_lsb_ready,
    input  logic [ROB_WIDTH_BIT-1:0] cdb_lsb_rob_id,
    input  logic [31:0]              cdb_lsb_value,
    output logic                     full,
    output logic                     alu_valid,
    output logic [RS_TYPE_BIT-1:0]   alu_work_type,
    output logic [31:0]              alu_r1,
    output logic [31:0]              alu_r2,
    output logic [ROB_WIDTH_BIT-1:0] alu_rob_id
);
    localparam int unsigned IdxW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic                     busy;
        logic [RS_TYPE_BIT-1:0]   op;
        logic [31:0]              vj;
        logic [31:0]              vk;
        logic                     has_qj;
        logic [ROB_WIDTH_BIT-1:0] qj;
        logic                     has_qk;
        logic [ROB_WIDTH_BIT-1:0] qk;
        logic [ROB_WIDTH_BIT-1:0] rob_id;
    } entry_t;

    typedef struct packed {
        logic        pending;
        logic [31:0] value;
    } opnd_t;

    // ALU bus is checked first so it wins when both buses carry the same tag.
    function automatic opnd_t snoop(input logic                     has_q,
                                    input logic [ROB_WIDTH_BIT-1:0] q,
                                    input logic [31:0]              v,
                                    input logic                     a_rdy,
                                    input logic [ROB_WIDTH_BIT-1:0] a_id,
                                    input logic [31:0]              a_val,
                                    input logic                     l_rdy,
                                    input logic [ROB_WIDTH_BIT-1:0] l_id,
                                    input logic [31:0]              l_val);
        opnd_t r;
        r.pending = has_q;
        r.value   = v;
        if (has_q && a_rdy && (q == a_id)) begin
            r.pending = 1'b0;
            r.value   = a_val;
        end else if (has_q && l_rdy && (q == l_id)) begin
            r.pending = 1'b0;
            r.value   = l_val;
        end
        return r;
    endfunction

    entry_t                   ent_q [RS_SIZE];
    entry_t                   ent_d [RS_SIZE];
    opnd_t                    snp_j [RS_SIZE];
    opnd_t                    snp_k [RS_SIZE];
    opnd_t                    disp_j;
    opnd_t                    disp_k;
    logic [RS_SIZE-1:0]       busy_vec;
    logic [RS_SIZE-1:0]       cand_vec;
    logic                     sel_found;
    logic                     free_found;
    logic [IdxW-1:0]          sel_idx;
    logic [IdxW-1:0]          free_idx;

    logic                     alu_valid_q;
    logic [RS_TYPE_BIT-1:0]   alu_type_q;
    logic [31:0]              alu_r1_q;
    logic [31:0]              alu_r2_q;
    logic [ROB_WIDTH_BIT-1:0] alu_rob_q;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            snp_j[i] = snoop(ent_q[i].has_qj, ent_q[i].qj, ent_q[i].vj,
                             cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                             cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value);
            snp_k[i] = snoop(ent_q[i].has_qk, ent_q[i].qk, ent_q[i].vk,
                             cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                             cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value);
            busy_vec[i] = ent_q[i].busy;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
            cand_vec[i] = ent_q[i].busy && !snp_j[i].pending && !snp_k[i].pending;
`else
            cand_vec[i] = ent_q[i].busy && !ent_q[i].has_qj && !ent_q[i].has_qk;
`endif
        end
    end

    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (cand_vec[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
            if (!busy_vec[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    assign full = &busy_vec;

    always_comb begin
        disp_j = snoop(disp_has_qj, disp_qj, disp_vj,
                       cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                       cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value);
        disp_k = snoop(disp_has_qk, disp_qk, disp_vk,
                       cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value,
                       cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value);
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i]        = ent_q[i];
            ent_d[i].has_qj = snp_j[i].pending;
            ent_d[i].vj     = snp_j[i].value;
            ent_d[i].has_qk = snp_k[i].pending;
            ent_d[i].vk     = snp_k[i].value;
        end
        if (sel_found) begin
            ent_d[sel_idx].busy = 1'b0;
        end
        // The free slot comes from registered state, so it never collides with the issuing slot.
        if (disp_valid && !full && free_found) begin
            ent_d[free_idx] = '{busy:   1'b1,
                                op:     disp_type,
                                vj:     disp_j.value,
                                vk:     disp_k.value,
                                has_qj: disp_j.pending,
                                qj:     disp_qj,
                                has_qk: disp_k.pending,
                                qk:     disp_qk,
                                rob_id: disp_rob_id};
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_type_q  <= '0;
            alu_r1_q    <= '0;
            alu_r2_q    <= '0;
            alu_rob_q   <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent_q[i].busy <= 1'b0;
                end
                alu_valid_q <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    ent_q[i] <= ent_d[i];
                end
                alu_valid_q <= sel_found;
                if (sel_found) begin
                    // Snooped values equal the stored ones unless a bypass wakeup is forwarding.
                    alu_type_q <= ent_q[sel_idx].op;
                    alu_r1_q   <= snp_j[sel_idx].value;
                    alu_r2_q   <= snp_k[sel_idx].value;
                    alu_rob_q  <= ent_q[sel_idx].rob_id;
                end
            end
        end
    end

    assign alu_valid     = alu_valid_q;
    assign alu_work_type = alu_type_q;
    assign alu_r1        = alu_r1_q;
    assign alu_r2        = alu_r2_q;
    assign alu_rob_id    = alu_rob_q;

endmodule
